alu_sequencer: RTL and testbench

//  Controller for the Phase-1 ALU. Accepts one operation per start/done handshake and registers
//  the operands and opcode that drive the combinational ALU. Captures the ALU's 64-bit result into
//  the Z register pair (z_hi/z_lo).

---
 rtl/alu_sequencer.sv | 174 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: operation controller in front of the Phase-1 combinational ALU.
// It latches each accepted operation into the ALU input registers and captures the
// 64-bit ALU result into Z (z_hi/z_lo). Multiply results get a programmable settle
// window. Signed division bypasses the ALU and runs here as a restoring divider
// with one iteration per clock.
module alu_sequencer #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 1
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [4:0]           opcode,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic [2*WIDTH-1:0]   alu_c,
  output logic [4:0]           alu_opcode,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     z_hi,
  output logic [WIDTH-1:0]     z_lo
);

  // Opcodes this block treats specially, in the CPU's instruction encoding.
  localparam logic [4:0] OP_MUL = 5'b10000;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NOP = 5'b11010;

  // The counter covers both the divider iterations (0..WIDTH-1) and the
  // multiply settle window (at most 15 cycles).
  localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
  localparam logic [4:0] DIV_LAST = 5'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_DIV,
    S_DFIX,
    S_DONE
  } state_t;

  state_t             state_reg;
  logic [4:0]         cnt_reg;
  logic [WIDTH-1:0]   quo_reg;
  logic [WIDTH:0]     rem_reg;
  logic [WIDTH-1:0]   dvs_reg;
  logic               sign_q_reg;
  logic               sign_r_reg;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH+1:0]   shift_rem;
  logic [WIDTH+1:0]   trial;
  logic               trial_ok;

  // The operations that produce a Z result through the ALU:
  // add..ori (except div), neg, not, and mul.
  function automatic logic writes_z(input logic [4:0] op);
    writes_z = ((op >= 5'b00011) && (op <= 5'b01110)) ||
               (op == 5'b10001) || (op == 5'b10010) || (op == OP_MUL);
  endfunction

  // Operand magnitudes for the divider, and one restoring step. The shifted
  // remainder is kept one bit wider than needed so the sign of the trial
  // subtraction is directly visible.
  always_comb begin
    abs_a     = op_a[WIDTH-1] ? -op_a : op_a;
    abs_b     = op_b[WIDTH-1] ? -op_b : op_b;
    shift_rem = {rem_reg, quo_reg[WIDTH-1]};
    trial     = shift_rem - {2'b00, dvs_reg};
    trial_ok  = ~trial[WIDTH+1];
  end

  // Sequencer FSM: handles accept, execution, divide iterations and result
  // capture. All outputs are registered here.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      quo_reg    <= '0;
      rem_reg    <= '0;
      dvs_reg    <= '0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      z_hi       <= '0;
      z_lo       <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            alu_opcode <= opcode;
            alu_a      <= op_a;
            alu_b      <= op_b;
            err        <= 1'b0;
            cnt_reg    <= '0;
            busy       <= 1'b1;
            if ((opcode == OP_DIV) && (op_b != '0)) begin
              // Start the divider on magnitudes. The signs are applied in DFIX.
              quo_reg    <= abs_a;
              dvs_reg    <= abs_b;
              rem_reg    <= '0;
              sign_q_reg <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
              sign_r_reg <= op_a[WIDTH-1];
              state_reg  <= S_DIV;
            end else begin
              state_reg  <= S_EXEC;
            end
          end else begin
            busy      <= 1'b0;
            state_reg <= S_IDLE;
          end
        end

        S_EXEC: begin
          if ((alu_opcode == OP_MUL) && (cnt_reg != MUL_LAST)) begin
            cnt_reg <= cnt_reg + 5'd1;
          end else begin
            if (writes_z(alu_opcode)) begin
              z_hi <= alu_c[2*WIDTH-1:WIDTH];
              z_lo <= alu_c[WIDTH-1:0];
            end else if (alu_opcode != OP_NOP) begin
              // Either a zero-divisor div or an undefined opcode. Z is kept.
              err <= 1'b1;
            end
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= S_DONE;
          end
        end

        S_DIV: begin
          if (trial_ok) begin
            rem_reg <= trial[WIDTH:0];
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
          end else begin
            rem_reg <= shift_rem[WIDTH:0];
            quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
          end
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == DIV_LAST) begin
            state_reg <= S_DFIX;
          end
        end

        S_DFIX: begin
          // Truncating division: the quotient takes the XOR of the operand signs,
          // and the remainder takes the dividend's sign.
          z_lo      <= sign_q_reg ? -quo_reg : quo_reg;
          z_hi      <= sign_r_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
          busy      <= 1'b0;
          done      <= 1'b1;
          state_reg <= S_DONE;
        end

        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer.
// A behavioural ALU drives alu_c. Expected Z/err values and completion cycles are
// queued when an operation is accepted, then compared whenever done pulses.
module tb_alu_sequencer;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_MUL = 5'b10000;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NOP = 5'b11010;
  localparam logic [4:0] OP_BAD = 5'b11111;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  opcode = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [63:0] alu_c;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] z_hi;
  logic [31:0] z_lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  alu_sequencer #(.WIDTH(32), .MUL_CYCLES(3)) dut (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode),
    .op_a(op_a), .op_b(op_b), .alu_c(alu_c), .alu_opcode(alu_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .busy(busy), .done(done), .err(err),
    .z_hi(z_hi), .z_lo(z_lo)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural ALU. A div opcode returns junk, because the sequencer must not use it.
  always_comb begin
    alu_c = 64'hDEAD_BEEF_0BAD_F00D;
    case (alu_opcode)
      OP_ADD:   alu_c = {32'b0, alu_a + alu_b};
      OP_SUB:   alu_c = {32'b0, alu_a - alu_b};
      5'b01010: alu_c = {32'b0, alu_a & alu_b};
      5'b01011: alu_c = {32'b0, alu_a | alu_b};
      OP_MUL:   alu_c = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});
      default:  alu_c = 64'hDEAD_BEEF_0BAD_F00D;
    endcase
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model of the Z pair and err.
  task automatic predict(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic e);
    logic [63:0] p;
    e = 1'b0;
    case (opc)
      OP_ADD: begin model_hi = '0; model_lo = a + b; end
      OP_SUB: begin model_hi = '0; model_lo = a - b; end
      OP_MUL: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        model_hi = p[63:32];
        model_lo = p[31:0];
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          model_lo = 32'h8000_0000;
          model_hi = 32'd0;
        end else begin
          model_lo = $signed(a) / $signed(b);
          model_hi = $signed(a) % $signed(b);
        end
      end
      OP_NOP: ;
      default: e = 1'b1;
    endcase
    hi = model_hi;
    lo = model_lo;
  endtask

  // Drive one operation with a single start pulse, and queue its expected result
  // and completion edge.
  task automatic issue(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input string tag);
    exp_t e;
    @(negedge clock);
    start = 1'b1; opcode = opc; op_a = a; op_b = b;
    @(posedge clock);
    #1;
    predict(opc, a, b, e.hi, e.lo, e.err);
    e.cyc = cyc + lat;
    e.tag = tag;
    sb.push_back(e);
    check_val({tag, "_opc"}, 64'(alu_opcode), 64'(opc));
    @(negedge clock);
    start = 1'b0;
  endtask

  // Wait for the scoreboard to empty. A cycle budget bounds the wait.
  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      check_val({tag, "_timeout"}, 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clock);
  endtask

  // Result monitor: each done pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!clear && done) begin
      if (sb.size() == 0) begin
        check_val("spurious_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        $display("txn %s: z_hi=%h z_lo=%h err=%b edge=%0d", mon_e.tag, z_hi, z_lo, err, cyc);
        check_val({mon_e.tag, "_hi"}, 64'(z_hi), 64'(mon_e.hi));
        check_val({mon_e.tag, "_lo"}, 64'(z_lo), 64'(mon_e.lo));
        check_val({mon_e.tag, "_err"}, 64'(err), 64'(mon_e.err));
        check_val({mon_e.tag, "_lat"}, 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e1;
    exp_t e2;
    repeat (3) @(negedge clock);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_err", 64'(err), 64'd0);
    check_val("rst_z", {z_hi, z_lo}, 64'd0);
    check_val("rst_alu", {27'd0, alu_opcode, alu_a}, 64'd0);
    clear = 1'b0;
    repeat (2) @(negedge clock);

    issue(OP_ADD, 32'd5, 32'd7, 1, "add");
    drain("add");
    issue(OP_DIV, -32'sd7, 32'd2, 33, "div_m7_2");
    drain("div_m7_2");
    issue(OP_DIV, 32'd100, 32'd7, 33, "div_100_7");
    drain("div_100_7");
    issue(OP_DIV, 32'd7, -32'sd2, 33, "div_7_m2");
    drain("div_7_m2");
    issue(OP_ADD, 32'd5, 32'd7, 1, "add2");
    drain("add2");
    issue(OP_DIV, 32'd55, 32'd0, 1, "div0");
    drain("div0");
    check_val("err_hold", 64'(err), 64'd1);
    issue(OP_BAD, 32'd1, 32'd2, 1, "undef");
    drain("undef");
    issue(OP_NOP, 32'd9, 32'd9, 1, "nop");
    drain("nop");
    issue(OP_SUB, 32'd3, 32'd10, 1, "sub");
    drain("sub");

    // Multiply with a 3-cycle window. A start pulse arrives while busy and must be ignored.
    issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 3, "mul");
    @(negedge clock);
    start = 1'b1; opcode = OP_ADD; op_a = 32'd1; op_b = 32'd1;
    @(negedge clock);
    start = 1'b0;
    check_val("mul_busy_opc", 64'(alu_opcode), 64'(OP_MUL));
    check_val("mul_busy_a", 64'(alu_a), 64'h0001_0000);
    drain("mul");

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, "div_ovf");
    drain("div_ovf");

    // Back-to-back: start stays high, so the second add is accepted in the DONE cycle.
    @(negedge clock);
    start = 1'b1; opcode = OP_ADD; op_a = 32'd1; op_b = 32'd2;
    @(posedge clock);
    #1;
    predict(OP_ADD, 32'd1, 32'd2, e1.hi, e1.lo, e1.err);
    e1.cyc = cyc + 1; e1.tag = "b2b_1";
    sb.push_back(e1);
    @(negedge clock);
    op_a = 32'd10; op_b = 32'd20;
    @(posedge clock);
    @(posedge clock);
    #1;
    predict(OP_ADD, 32'd10, 32'd20, e2.hi, e2.lo, e2.err);
    e2.cyc = e1.cyc + 2; e2.tag = "b2b_2";
    sb.push_back(e2);
    check_val("b2b_accept_a", 64'(alu_a), 64'd10);
    @(negedge clock);
    start = 1'b0;
    drain("b2b");

    // Asynchronous clear during divider iteration 10.
    issue(OP_DIV, 32'd1000, 32'd3, 33, "div_abort");
    repeat (10) @(posedge clock);
    #3;
    clear = 1'b1;
    #1;
    sb.delete();
    model_hi = '0;
    model_lo = '0;
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_done", 64'(done), 64'd0);
    check_val("abort_err", 64'(err), 64'd0);
    check_val("abort_z", {z_hi, z_lo}, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    repeat (2) @(negedge clock);
    issue(OP_ADD, 32'd5, 32'd7, 1, "add_after_clr");
    drain("add_after_clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
